// File: rtl/frac_n_sdm.sv
// frac_n_sdm: MASH 1-1-1 sigma-delta controller for a fractional-N divider.
// Emits one clamped integer divide ratio per enabled reference cycle.
module frac_n_sdm #(
    parameter int N_W    = 8,
    parameter int FRAC_W = 16,
    parameter int ORDER  = 3,
    parameter int DITHER = 0,
    parameter int N_MIN  = 4,
    parameter int N_MAX  = 250,
    parameter int N_RST  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [N_W-1:0]    n_int,
    input  logic [FRAC_W-1:0] frac,
    output logic [N_W-1:0]    n_out,
    output logic              n_valid,
    output logic              sat
);

    localparam int Y_W = N_W + 3;
    localparam int S_W = N_W + 4;
    localparam logic signed [S_W-1:0] S_MIN = S_W'(N_MIN);
    localparam logic signed [S_W-1:0] S_MAX = S_W'(N_MAX);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    if (ORDER < 1 || ORDER > 3) begin : g_bad_order
        $error("frac_n_sdm: ORDER must be in 1..3");
    end

    logic [N_W-1:0]    cfg_int_q, cfg_int_d;
    logic [FRAC_W-1:0] cfg_frac_q, cfg_frac_d;
    logic [FRAC_W-1:0] acc1_q, acc1_d;
    logic [FRAC_W-1:0] acc2_q, acc2_d;
    logic [FRAC_W-1:0] acc3_q, acc3_d;
    logic              c2_dly_q, c2_dly_d;
    logic              c3_dly_q, c3_dly_d;
    logic              c3_ddly_q, c3_ddly_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [N_W-1:0]    n_out_q, n_out_d;
    logic              n_valid_q, n_valid_d;
    logic              sat_q, sat_d;

    logic              dither;
    logic              lfsr_fb;
    logic [FRAC_W:0]   sum1, sum2, sum3;
    logic              c1, c2, c3;
    logic [Y_W-1:0]    y;
    logic signed [S_W-1:0] s;

    always_comb begin
        cfg_int_d  = cfg_int_q;
        cfg_frac_d = cfg_frac_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        acc3_d     = acc3_q;
        c2_dly_d   = c2_dly_q;
        c3_dly_d   = c3_dly_q;
        c3_ddly_d  = c3_ddly_q;
        lfsr_d     = lfsr_q;
        n_out_d    = n_out_q;
        sat_d      = sat_q;
        n_valid_d  = 1'b0;

        dither  = (DITHER != 0) && lfsr_q[0];
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

        // Each stage sees the freshly updated residue of the previous one.
        sum1 = {1'b0, acc1_q} + {1'b0, cfg_frac_q} + (FRAC_W+1)'(dither);
        sum2 = {1'b0, acc2_q} + {1'b0, sum1[FRAC_W-1:0]};
        sum3 = {1'b0, acc3_q} + {1'b0, sum2[FRAC_W-1:0]};
        c1   = sum1[FRAC_W];
        c2   = sum2[FRAC_W];
        c3   = sum3[FRAC_W];

        // Two's-complement arithmetic modulo 2^Y_W; range is far inside it.
        y = Y_W'(c1);
        if (ORDER >= 2) begin
            y = y + Y_W'(c2) - Y_W'(c2_dly_q);
        end
        if (ORDER >= 3) begin
            y = y + Y_W'(c3) - Y_W'({c3_dly_q, 1'b0}) + Y_W'(c3_ddly_q);
        end

        s = S_W'(cfg_int_q) + {y[Y_W-1], y};

        if (en) begin
            acc1_d    = sum1[FRAC_W-1:0];
            acc2_d    = sum2[FRAC_W-1:0];
            acc3_d    = sum3[FRAC_W-1:0];
            c2_dly_d  = c2;
            c3_ddly_d = c3_dly_q;
            c3_dly_d  = c3;
            n_valid_d = 1'b1;
            if (DITHER != 0) begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            end
            if (s < S_MIN) begin
                n_out_d = N_W'(N_MIN);
                sat_d   = 1'b1;
            end else if (s > S_MAX) begin
                n_out_d = N_W'(N_MAX);
                sat_d   = 1'b1;
            end else begin
                n_out_d = s[N_W-1:0];
                sat_d   = 1'b0;
            end
        end

        // Capture lands after this step, so a same-cycle step uses old config.
        if (load) begin
            cfg_int_d  = n_int;
            cfg_frac_d = frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_int_q  <= N_W'(N_RST);
            cfg_frac_q <= '0;
            acc1_q     <= '0;
            acc2_q     <= '0;
            acc3_q     <= '0;
            c2_dly_q   <= 1'b0;
            c3_dly_q   <= 1'b0;
            c3_ddly_q  <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            n_out_q    <= N_W'(N_RST);
            n_valid_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            cfg_int_q  <= cfg_int_d;
            cfg_frac_q <= cfg_frac_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            acc3_q     <= acc3_d;
            c2_dly_q   <= c2_dly_d;
            c3_dly_q   <= c3_dly_d;
            c3_ddly_q  <= c3_ddly_d;
            lfsr_q     <= lfsr_d;
            n_out_q    <= n_out_d;
            n_valid_q  <= n_valid_d;
            sat_q      <= sat_d;
        end
    end

    assign n_out   = n_out_q;
    assign n_valid = n_valid_q;
    assign sat     = sat_q;

endmodule
